spi_core_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_core` 32-bit packet engine between `NUM_REQ` requesters. It sits between the requesters (Avalon slave logic, boot loader, housekeeping poller) and the core's `go_transfer` / `data_write_from_avalon` / `data_read_to_avalon` / `data_pack_ready` port set. Each accepted request causes exactly one 4-byte SPI packet. The winning requester receives the read word with a one-cycle done pulse. A watchdog frees the core if `data_pack_ready` never arrives.

---
 rtl/spi_core_arbiter.sv | 120 ++++++++++++
 tb/tb_spi_core_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_core_arbiter
// Function : Round-robin arbiter/sequencer sharing one spi_core packet engine.
// Revision : 1.0
// ============================================================================
module spi_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  spi_go,
    output logic [31:0]           spi_wdata,
    input  logic [31:0]           spi_rdata,
    input  logic                  spi_pack_ready
);

    localparam int              IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [15:0]     C_TIMEOUT = 16'(TIMEOUT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_last;
    logic [15:0]        r_wdog;

    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic               w_found;
    int                 w_pos;

    // Scan upward from the previous winner so the last owner is considered last.
    always_comb begin
        w_winner     = r_last;
        w_win_onehot = '0;
        w_found      = 1'b0;
        w_idx        = '0;
        w_pos        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_pos = (int'(r_last) + i) % NUM_REQ;
            w_idx = IDX_W'(w_pos);
            if (!w_found && req[w_idx]) begin
                w_found             = 1'b1;
                w_winner            = w_idx;
                w_win_onehot[w_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_last    <= LAST_RST;
            r_wdog    <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            spi_go    <= 1'b0;
            spi_wdata <= '0;
        end else begin
            done   <= '0;
            err    <= 1'b0;
            spi_go <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        grant     <= w_win_onehot;
                        spi_wdata <= wdata[{w_winner, 5'b00000} +: 32];
                        r_last    <= w_winner;
                        busy      <= 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    spi_go  <= 1'b1;
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wdog <= r_wdog + 16'd1;
                    if (spi_pack_ready) begin
                        rdata   <= spi_rdata;
                        done    <= grant;
                        r_state <= ST_RELEASE;
                    end else if (r_wdog == C_TIMEOUT) begin
                        done    <= grant;
                        err     <= 1'b1;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A still-high ready would complete the next packet instantly.
                    if (!spi_pack_ready) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_core_arbiter
// Function : Scoreboard bench for spi_core_arbiter with a simple spi_core model.
// Revision : 1.0
// ============================================================================
module tb_spi_core_arbiter;

    localparam int          N   = 4;
    localparam logic [31:0] KEY = 32'h7B08_ACDB;  // 0xA5A51234 ^ KEY == 0xDEADBEEF

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [32*N-1:0] wdata;
    logic [N-1:0]    grant, done;
    logic            err, busy, spi_go, spi_pack_ready;
    logic [31:0]     rdata, spi_wdata, spi_rdata;

    logic [1:0]      req2, grant2, done2;
    logic [63:0]     wdata2;
    logic            err2, busy2, spi_go2;
    logic [31:0]     rdata2, spi_wdata2;

    always #5 clk = ~clk;

    spi_core_arbiter #(.NUM_REQ(N), .TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .grant(grant), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .spi_go(spi_go), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .spi_pack_ready(spi_pack_ready)
    );

    spi_core_arbiter #(.NUM_REQ(2), .TIMEOUT(15)) dut_to (
        .clk(clk), .reset(reset), .req(req2), .wdata(wdata2),
        .grant(grant2), .done(done2), .err(err2), .rdata(rdata2), .busy(busy2),
        .spi_go(spi_go2), .spi_wdata(spi_wdata2), .spi_rdata(32'h1111_2222),
        .spi_pack_ready(1'b0)
    );

    typedef struct {
        int          idx;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   go_cnt   = 0;
    logic prev_go  = 1'b0;
    int   core_lat = 8;
    int   core_cnt;
    logic core_act;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic [31:0] w);
        exp_t e;
        e.idx = i;
        e.wd  = w;
        sb.push_back(e);
    endtask

    // spi_core stand-in: ready (held two cycles) core_lat cycles after go.
    always @(posedge clk) begin
        if (reset) begin
            core_act       <= 1'b0;
            core_cnt       <= 0;
            spi_pack_ready <= 1'b0;
            spi_rdata      <= '0;
        end else if (spi_go) begin
            core_act       <= 1'b1;
            core_cnt       <= 0;
            spi_pack_ready <= 1'b0;
        end else if (core_act) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == core_lat - 1) begin
                spi_pack_ready <= 1'b1;
                spi_rdata      <= spi_wdata ^ KEY;
            end else if (core_cnt == core_lat + 1) begin
                spi_pack_ready <= 1'b0;
                core_act       <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (spi_go) begin
                go_cnt++;
                check("go_single", 32'(prev_go), 32'd0);
                if (sb.size() == 0) begin
                    check("go_unexpected", 32'd1, 32'd0);
                end else begin
                    check("go_grant", 32'(grant), 32'd1 << sb[0].idx);
                    check("go_wdata", spi_wdata, sb[0].wd);
                end
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_owner", 32'(done), 32'd1 << mon_e.idx);
                    check("done_rdata", rdata, mon_e.wd ^ KEY);
                    check("done_err", 32'(err), 32'd0);
                end
            end
        end
        prev_go = spi_go;
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        req2  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic run_until_idle(input int base, input int stop_after, input int bound);
        int k = 0;
        while (k < bound) begin
            @(posedge clk);
            #1;
            k++;
            if (go_cnt - base >= stop_after) req = '0;
            if (sb.size() == 0 && !busy && req == '0) break;
        end
        if (k >= bound) check("run_bound_expired", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        int k;
        reset  = 1'b1;
        req    = '0;
        req2   = '0;
        wdata  = '0;
        wdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rdata", rdata,      32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_go",    32'(spi_go), 32'd0);
        check("rst_wdata", spi_wdata,  32'd0);
        reset = 1'b0;

        // Single request, owner drops req one cycle after grant.
        wdata[31:0] = 32'hA5A5_1234;
        core_lat    = 70;
        push_exp(0, 32'hA5A5_1234);
        base = go_cnt;
        @(posedge clk); #1;
        req = 4'b0001;
        @(posedge clk); #1;
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy",  32'(busy),  32'h1);
        check("t1_spi_wdata", spi_wdata, 32'hA5A5_1234);
        check("t1_go_early", 32'(spi_go), 32'h0);
        @(posedge clk); #1;
        check("t1_go", 32'(spi_go), 32'h1);
        req = '0;
        run_until_idle(base, 1, 400);
        repeat (6) @(posedge clk);
        #1;
        check("t1_go_count", 32'(go_cnt - base), 32'd1);
        check("t1_rdata",    rdata, 32'hDEAD_BEEF);
        check("t1_grant_free", 32'(grant), 32'd0);

        // Simultaneous requests 1 and 3 from reset.
        do_reset();
        core_lat       = 8;
        wdata[63:32]   = 32'h1357_9BDF;
        wdata[127:96]  = 32'h0F0F_3C3C;
        push_exp(1, 32'h1357_9BDF);
        push_exp(3, 32'h0F0F_3C3C);
        base = go_cnt;
        req  = 4'b1010;
        run_until_idle(base, 2, 500);
        check("t2_go_count", 32'(go_cnt - base), 32'd2);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // All requesters held for 8 packets.
        do_reset();
        wdata = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        for (int p = 0; p < 8; p++) push_exp(p % 4, wdata[32*(p%4) +: 32]);
        base = go_cnt;
        req  = 4'b1111;
        run_until_idle(base, 8, 2000);
        check("t3_go_count", 32'(go_cnt - base), 32'd8);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while waiting on the core, then all request: 0 wins first.
        do_reset();
        core_lat = 50;
        push_exp(2, wdata[95:64]);
        req = 4'b0100;
        k   = 0;
        while (!spi_go && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_go_seen", 32'(spi_go), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        @(posedge clk); #1;
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_busy",  32'(busy),  32'd0);
        check("t5_go",    32'(spi_go), 32'd0);
        check("t5_wdata", spi_wdata, 32'd0);
        check("t5_rdata", rdata, 32'd0);
        sb.delete();
        reset    = 1'b0;
        core_lat = 8;
        push_exp(0, wdata[31:0]);
        base = go_cnt;
        req  = 4'b1111;
        run_until_idle(base, 1, 500);
        check("t5_go_count", 32'(go_cnt - base), 32'd1);

        // Watchdog abort on the TIMEOUT=15 instance.
        do_reset();
        wdata2[31:0] = 32'hCAFE_0001;
        req2 = 2'b01;
        k    = 0;
        while (!spi_go2 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("t4_go_seen",  32'(spi_go2), 32'd1);
        check("t4_go_wdata", spi_wdata2, 32'hCAFE_0001);
        req2 = '0;
        k    = 0;
        while (done2 == '0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("t4_abort_delay", 32'(k), 32'd16);
        check("t4_done", 32'(done2), 32'h1);
        check("t4_err",  32'(err2),  32'h1);
        check("t4_rdata_held", rdata2, 32'd0);
        @(posedge clk); #1;
        check("t4_done_pulse", 32'(done2), 32'd0);
        check("t4_err_pulse",  32'(err2),  32'd0);
        check("t4_grant_free", 32'(grant2), 32'd0);
        check("t4_idle",       32'(busy2),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
